// File: rtl/bsg_fifo_1r1w_small_reset_n.sv
// Small 1R1W FIFO with registered storage, valid/ready in, valid/yumi out, and
// a sticky protocol-error flag. Reset is asynchronous and active-low.
module bsg_fifo_1r1w_small_reset_n #(
  parameter  int width_p           = 3,
  parameter  int els_p             = 4,
  parameter  bit assert_protocol_p = 1'b1,
  localparam int lg_els_lp         = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 v_i,
  input  logic [width_p-1:0]   data_i,
  output logic                 ready_o,
  output logic                 v_o,
  output logic [width_p-1:0]   data_o,
  input  logic                 yumi_i,
  output logic [lg_els_lp:0]   count_o,
  output logic                 err_o
);

  // Handshake: a word moves in when v_i & ready_o at posedge; the head moves out
  // when yumi_i & v_o at posedge. Asserting either strobe without its partner
  // signal is a violation: the strobe is ignored and err_o latches high.

  localparam logic [lg_els_lp:0] full_lp = (lg_els_lp+1)'(els_p);

  logic [width_p-1:0]   r_mem [els_p];
  logic [lg_els_lp-1:0] r_wr_ptr;
  logic [lg_els_lp-1:0] r_rd_ptr;
  logic [lg_els_lp:0]   r_count;
  logic                 r_err;

  logic w_enq;
  logic w_deq;
  logic w_viol;

  assign ready_o = (r_count != full_lp);
  assign v_o     = (r_count != '0);
  assign data_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;
  assign err_o   = r_err;

  assign w_enq  = v_i & ready_o;
  assign w_deq  = yumi_i & v_o;
  assign w_viol = (v_i & ~ready_o) | (yumi_i & ~v_o);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_enq) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      // Simultaneous enq+deq leaves occupancy unchanged.
      if (w_enq && !w_deq)      r_count <= r_count + 1'b1;
      else if (w_deq && !w_enq) r_count <= r_count - 1'b1;
      if (w_viol) r_err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  a_els_pow2: assert property (@(posedge clk_i)
    (els_p >= 2) && ((els_p & (els_p - 1)) == 0));
  a_no_enq_when_full: assert property (@(posedge clk_i)
    disable iff (!reset_n_i || !assert_protocol_p) !(v_i && !ready_o));
  a_no_deq_when_empty: assert property (@(posedge clk_i)
    disable iff (!reset_n_i || !assert_protocol_p) !(yumi_i && !v_o));
`endif

endmodule
